// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction fetch stage.
// Holds the fetch PC and keeps at most one word request outstanding to
// instruction memory. Returned words are queued with their PCs in a
// QDEPTH-entry FIFO for decode. A redirect loads a base+imm target, flushes
// the FIFO and discards any in-flight response.
// Optional build macro: IFU_PERF_CNT_EN adds perf_fetched, perf_redirects and
// perf_dropped event counters.
module fetch_queue_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              QDEPTH       = 4,
    parameter int              IMM_W        = 12
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_base,
    input  logic [IMM_W-1:0] redirect_imm,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst_data,
    output logic [XLEN-1:0]  inst_pc,
    output logic [XLEN-1:0]  fetch_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_redirects,
    output logic [31:0]      perf_dropped
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

    // IDLE: nothing outstanding; WAIT: response will be kept;
    // DROP: response will be discarded (a redirect overtook it).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [31:0]       data_mem_q [QDEPTH];
    logic [XLEN-1:0]   pc_mem_q   [QDEPTH];

    logic              req_fire;
    logic              push;
    logic              pop;
    logic              head_valid;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   target_sum;
    logic [XLEN-1:0]   target;

    assign imm_ext    = {{(XLEN-IMM_W){redirect_imm[IMM_W-1]}}, redirect_imm};
    assign target_sum = redirect_base + imm_ext;
    assign target     = {target_sum[XLEN-1:2], 2'b00};

    assign head_valid     = (count_q != {CW{1'b0}});
    assign imem_req_valid = (state_q == ST_IDLE) && (count_q < QDEPTH_C) &&
                            !redirect_valid && !reset;
    assign imem_req_addr  = pc_q;
    assign fetch_pc       = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_valid = head_valid;
    assign inst_data  = head_valid ? data_mem_q[rd_ptr_q] : 32'h0000_0000;
    assign inst_pc    = head_valid ? pc_mem_q[rd_ptr_q]   : {XLEN{1'b0}};

    // Next state, fetch PC and queue pointer/count update; redirect overrides all
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push     = 1'b0;
        pop      = head_valid && inst_ready && !redirect_valid;

        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = ST_IDLE;
                    push    = !redirect_valid;
                end else if (redirect_valid) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (redirect_valid) begin
            pc_d     = target;
            count_d  = {CW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
        end else begin
            if (req_fire) begin
                req_pc_d = pc_q;
                pc_d     = pc_q + XLEN'(4);
            end else begin
                req_pc_d = req_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_VECTOR;
            req_pc_q <= {XLEN{1'b0}};
            count_q  <= {CW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage: write the returned word and its request PC at the tail
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                data_mem_q[i] <= 32'h0000_0000;
                pc_mem_q[i]   <= {XLEN{1'b0}};
            end
        end else if (push) begin
            data_mem_q[wr_ptr_q] <= imem_rsp_data;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic        drop_rsp;
    logic [31:0] perf_fetched_q,   perf_fetched_d;
    logic [31:0] perf_redirects_q, perf_redirects_d;
    logic [31:0] perf_dropped_q,   perf_dropped_d;

    assign drop_rsp = imem_rsp_valid &&
                      ((state_q == ST_DROP) || ((state_q == ST_WAIT) && redirect_valid));

    // Event counters; they keep counting across redirects and wrap naturally
    always_comb begin
        perf_fetched_d   = perf_fetched_q   + {31'd0, push};
        perf_redirects_d = perf_redirects_q + {31'd0, redirect_valid};
        perf_dropped_d   = perf_dropped_q   + {31'd0, drop_rsp};
    end

    // Event counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q   <= 32'd0;
            perf_redirects_q <= 32'd0;
            perf_dropped_q   <= 32'd0;
        end else begin
            perf_fetched_q   <= perf_fetched_d;
            perf_redirects_q <= perf_redirects_d;
            perf_dropped_q   <= perf_dropped_d;
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_redirects = perf_redirects_q;
    assign perf_dropped   = perf_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: a reset/startup vector table, hand-written
// corner sequences, and randomized traffic checked against a queue-based
// reference model of the fetch stage.
module tb_fetch_queue_unit;

    localparam logic [31:0] RV = 32'h0000_0100;
    localparam int          QD = 4;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_base;
    logic [11:0] redirect_imm;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] fetch_pc;

    fetch_queue_unit #(
        .XLEN(32), .RESET_VECTOR(RV), .QDEPTH(QD), .IMM_W(12)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_base(redirect_base),
        .redirect_imm(redirect_imm),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .fetch_pc(fetch_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    int          m_out;   // 0 = nothing outstanding, 1 = keep response, 2 = discard

    task automatic m_reset();
        mq.delete();
        m_pc     = RV;
        m_req_pc = 32'h0;
        m_out    = 0;
    endtask

    task automatic m_check(input string tag);
        logic exp_rv;
        exp_rv = (m_out == 0) && (mq.size() < QD) && !redirect_valid;
        chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, exp_rv});
        chk({tag, ".req_addr"}, imem_req_addr, m_pc);
        chk({tag, ".fetch_pc"}, fetch_pc, m_pc);
        chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, (mq.size() > 0)});
        if (mq.size() > 0) begin
            chk({tag, ".inst_data"}, inst_data, mq[0].data);
            chk({tag, ".inst_pc"}, inst_pc, mq[0].pc);
        end
    endtask

    task automatic m_update();
        logic fire, rsp, popq;
        fire = (m_out == 0) && (mq.size() < QD) && !redirect_valid && imem_req_ready;
        rsp  = imem_rsp_valid && (m_out != 0);
        popq = inst_ready && (mq.size() > 0);
        if (redirect_valid) begin
            m_pc = (redirect_base + 32'($signed(redirect_imm))) & 32'hFFFF_FFFC;
            mq.delete();
            if (m_out != 0) m_out = rsp ? 0 : 2;
        end else begin
            if (popq) void'(mq.pop_front());
            if (rsp) begin
                if (m_out == 1) mq.push_back('{data: imem_rsp_data, pc: m_req_pc});
                m_out = 0;
            end
            if (fire) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
                m_out    = 1;
            end
        end
    endtask

    // One clock cycle with model checking; inputs set by caller after negedge
    task automatic cyc(input string tag);
        #1;
        m_check(tag);
        if (imem_req_valid && imem_req_ready) n_acc++;
        m_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        redirect_valid = 1'b0;
        redirect_base  = 32'h0;
        redirect_imm   = 12'h0;
        inst_ready     = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    // ---------------- startup vector table ----------------
    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rsp;
        logic [31:0] rdata;
        logic        iready;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_data;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // rst rdy rsp data           irdy | req_valid addr  inst_valid data  pc
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h100, 1'b0, 32'h0,         32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h100, 1'b0, 32'h0,         32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h100, 1'b0, 32'h0,         32'h0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h100, 1'b0, 32'h0,         32'h0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 32'hDEAD_0000, 1'b0, 1'b0, 32'h104, 1'b0, 32'h0,         32'h0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h104, 1'b1, 32'hDEAD_0000, 32'h100};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 32'hDEAD_0001, 1'b1, 1'b0, 32'h108, 1'b0, 32'h0,         32'h0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h108, 1'b1, 32'hDEAD_0001, 32'h104};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 32'hDEAD_0002, 1'b1, 1'b0, 32'h10C, 1'b0, 32'h0,         32'h0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h10C, 1'b1, 32'hDEAD_0002, 32'h108};

        reset = 1'b1;
        idle_in();
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            reset          = tbl[i].rst;
            imem_req_ready = tbl[i].rdy;
            imem_rsp_valid = tbl[i].rsp;
            imem_rsp_data  = tbl[i].rdata;
            inst_ready     = tbl[i].iready;
            #1;
            chk($sformatf("tbl%0d.req_valid", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].e_rv});
            chk($sformatf("tbl%0d.req_addr", i), imem_req_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d.fetch_pc", i), fetch_pc, tbl[i].e_addr);
            chk($sformatf("tbl%0d.inst_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].e_iv});
            if (tbl[i].e_iv || tbl[i].rst) begin
                chk($sformatf("tbl%0d.inst_data", i), inst_data, tbl[i].e_data);
                chk($sformatf("tbl%0d.inst_pc", i), inst_pc, tbl[i].e_pc);
            end
            @(posedge clk);
            @(negedge clk);
        end

        // ---- backpressure: exactly QD requests with decode stalled ----
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            idle_in();
            imem_req_ready = 1'b1;
            imem_rsp_valid = (m_out == 1);
            cyc("bp_fill");
        end
        chk("bp.requests_when_full", n_acc, 32'd4);
        idle_in();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        cyc("bp_pop");
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            idle_in();
            imem_req_ready = 1'b1;
            imem_rsp_valid = (m_out == 1);
            cyc("bp_refill");
        end
        chk("bp.requests_after_pop", n_acc, 32'd1);

        // ---- redirect with an outstanding request ----
        do_reset();
        idle_in();
        redirect_valid = 1'b1;
        redirect_base  = 32'h10;
        cyc("rd_to10");
        idle_in();
        imem_req_ready = 1'b1;
        #1;
        chk("rd.req_addr_10", imem_req_addr, 32'h10);
        cyc("rd_accept10");
        idle_in();
        redirect_valid = 1'b1;
        redirect_base  = 32'h40;
        redirect_imm   = 12'hFF8;
        cyc("rd_redirect");
        idle_in();
        #1;
        chk("rd.fetch_pc_38", fetch_pc, 32'h38);
        chk("rd.no_req_in_drop", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0010;
        cyc("rd_late_rsp");
        idle_in();
        imem_req_ready = 1'b1;
        cyc("rd_req38");
        idle_in();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0038;
        cyc("rd_rsp38");
        idle_in();
        #1;
        chk("rd.inst_pc_38", inst_pc, 32'h38);
        chk("rd.inst_data_38", inst_data, 32'h0000_0038);
        cyc("rd_head38");

        // ---- redirect + response + pop in the same cycle ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle_in();
            imem_req_ready = 1'b1;
            imem_rsp_valid = (m_out == 1);
            cyc("sim_fill");
        end
        idle_in();
        imem_req_ready = 1'b1;
        cyc("sim_accept");
        idle_in();
        redirect_valid = 1'b1;
        redirect_base  = 32'h200;
        redirect_imm   = 12'h010;
        imem_rsp_valid = 1'b1;
        inst_ready     = 1'b1;
        cyc("sim_all");
        idle_in();
        #1;
        chk("sim.inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("sim.req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("sim.req_addr", imem_req_addr, 32'h210);
        cyc("sim_after");

        // ---- alignment and wrap of the redirect target ----
        idle_in();
        redirect_valid = 1'b1;
        redirect_base  = 32'hFFFF_FFFE;
        redirect_imm   = 12'h003;
        cyc("wrap_redirect");
        idle_in();
        imem_req_ready = 1'b1;
        #1;
        chk("wrap.addr0", imem_req_addr, 32'h0);
        cyc("wrap_req0");
        idle_in();
        imem_rsp_valid = 1'b1;
        cyc("wrap_rsp0");
        idle_in();
        imem_req_ready = 1'b1;
        #1;
        chk("wrap.addr4", imem_req_addr, 32'h4);
        cyc("wrap_req4");

        // ---- asynchronous reset while a request is outstanding ----
        idle_in();
        imem_rsp_valid = 1'b1;
        cyc("ar_rsp4");
        idle_in();
        imem_req_ready = 1'b1;
        cyc("ar_accept");
        idle_in();
        #2;
        reset = 1'b1;
        #1;
        chk("ar.req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("ar.inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("ar.fetch_pc", fetch_pc, RV);
        chk("ar.inst_data", inst_data, 32'h0);
        chk("ar.inst_pc", inst_pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        cyc("ar_late_rsp");
        idle_in();
        imem_req_ready = 1'b1;
        #1;
        chk("ar.restart_addr", imem_req_addr, RV);
        cyc("ar_restart");
        idle_in();
        imem_rsp_valid = 1'b1;
        cyc("ar_rsp");
        idle_in();
        cyc("ar_head");

        // ---- randomized traffic against the reference model ----
        do_reset();
        for (int i = 0; i < 600; i++) begin
            idle_in();
            imem_req_ready = ($urandom_range(0, 3) != 0);
            if (m_out != 0) imem_rsp_valid = ($urandom_range(0, 1) == 1);
            else            imem_rsp_valid = ($urandom_range(0, 7) == 0);
            imem_rsp_data  = $urandom;
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_base  = $urandom;
            redirect_imm   = 12'($urandom);
            cyc("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Bound the whole run
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
